// File: rtl/sram2d_pkg.sv
// Shared sizing defaults and operation encoding for the 8x8 scratch SRAM.
package sram2d_pkg;

    localparam int DATA_W   = 8;
    localparam int ROW_BITS = 3;
    localparam int COL_BITS = 3;
    localparam int ADDR_W   = ROW_BITS + COL_BITS;
    localparam int NUM_ROWS = 1 << ROW_BITS;
    localparam int NUM_COLS = 1 << COL_BITS;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } op_t;

endpackage

// File: rtl/sram2d_addr_dec.sv
// Splits a word address into one-hot row and column selects; all selects drop
// to zero while the chip is deselected.
module sram2d_addr_dec #(
    parameter int ROW_BITS = sram2d_pkg::ROW_BITS,
    parameter int COL_BITS = sram2d_pkg::COL_BITS
) (
    input  logic                         CS,
    input  logic [ROW_BITS+COL_BITS-1:0] Address,
    output logic [(1<<ROW_BITS)-1:0]     row_sel,
    output logic [(1<<COL_BITS)-1:0]     col_sel
);

    localparam int ADDR_W = ROW_BITS + COL_BITS;

    logic [ROW_BITS-1:0] row;
    logic [COL_BITS-1:0] col;

    assign row = Address[ADDR_W-1:COL_BITS];
    assign col = Address[COL_BITS-1:0];

    always_comb begin
        row_sel = '0;
        col_sel = '0;
        if (CS == 1'b0) begin
            row_sel[row] = 1'b1;
            col_sel[col] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_2d_array.sv
// Single-port 2D SRAM model (rows x cols of DATA_W words) with registered read.
// Define SRAM2D_PARITY_EN to store an even-parity bit per word and flag read errors.
module sram_2d_array
    import sram2d_pkg::*;
#(
    parameter int DATA_W   = sram2d_pkg::DATA_W,
    parameter int ROW_BITS = sram2d_pkg::ROW_BITS,
    parameter int COL_BITS = sram2d_pkg::COL_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         CS,
    input  logic                         RW_en,
    input  logic [DATA_W-1:0]            Data_in,
    input  logic [ROW_BITS+COL_BITS-1:0] Address,
    output logic [DATA_W-1:0]            Data_out,
    output logic                         parity_err
);

    localparam int ADDR_W   = ROW_BITS + COL_BITS;
    localparam int NUM_ROWS = 1 << ROW_BITS;
    localparam int NUM_COLS = 1 << COL_BITS;

    op_t                                          op;
    logic [NUM_ROWS-1:0]                          row_sel;
    logic [NUM_COLS-1:0]                          col_sel;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0][DATA_W-1:0] mem;
    logic [DATA_W-1:0]                            rd_word;

    // Only a clean 0/1 pair decodes to an access; X/Z falls through to idle.
    always_comb begin
        op = OP_IDLE;
        case ({CS, RW_en})
            2'b00:   op = OP_WRITE;
            2'b01:   op = OP_READ;
            default: op = OP_IDLE;
        endcase
    end

    sram2d_addr_dec #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS)
    ) u_addr_dec (
        .CS      (CS),
        .Address (Address),
        .row_sel (row_sel),
        .col_sel (col_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (op == OP_WRITE) begin
            for (int r = 0; r < NUM_ROWS; r++)
                for (int c = 0; c < NUM_COLS; c++)
                    if (row_sel[r] && col_sel[c])
                        mem[r][c] <= Data_in;
        end
    end

    // AND-OR read mux driven by the same one-hot selects as the write path.
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLS; c++)
                rd_word = rd_word | (mem[r][c] & {DATA_W{row_sel[r] & col_sel[c]}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            Data_out <= '0;
        else if (op == OP_READ)
            Data_out <= rd_word;
    end

`ifdef SRAM2D_PARITY_EN
    // Flat parity store, one bit per word at index row*NUM_COLS+col.
    logic [NUM_ROWS*NUM_COLS-1:0] par_bits;
    logic                         rd_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bits <= '0;
        end else if (op == OP_WRITE) begin
            for (int r = 0; r < NUM_ROWS; r++)
                for (int c = 0; c < NUM_COLS; c++)
                    if (row_sel[r] && col_sel[c])
                        par_bits[r*NUM_COLS+c] <= ^Data_in;
        end
    end

    always_comb begin
        rd_par = 1'b0;
        for (int r = 0; r < NUM_ROWS; r++)
            for (int c = 0; c < NUM_COLS; c++)
                rd_par = rd_par | (par_bits[r*NUM_COLS+c] & row_sel[r] & col_sel[c]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            parity_err <= 1'b0;
        else if (op == OP_READ)
            parity_err <= (^rd_word) ^ rd_par;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_2d_array.sv
// Directed self-checking bench for sram_2d_array (parity checks under SRAM2D_PARITY_EN).
module tb_sram_2d_array;

    logic       clk;
    logic       rst_n;
    logic       CS;
    logic       RW_en;
    logic [7:0] Data_in;
    logic [5:0] Address;
    logic [7:0] Data_out;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    sram_2d_array dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .CS         (CS),
        .RW_en      (RW_en),
        .Data_in    (Data_in),
        .Address    (Address),
        .Data_out   (Data_out),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Present one operation, let it be sampled, then settle just past the edge.
    task automatic cyc(input logic cs, input logic rw, input logic [7:0] d, input logic [5:0] a);
        CS      = cs;
        RW_en   = rw;
        Data_in = d;
        Address = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        CS      = 1'b1;
        RW_en   = 1'b1;
        Data_in = 8'h00;
        Address = 6'h00;
        #3;
        chk("rst_dout", Data_out, 8'h00);
        chk("rst_perr", {7'b0, parity_err}, 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc(1'b0, 1'b1, 8'h00, 6'h00);
        chk("rd_0x00", Data_out, 8'h00);
        cyc(1'b0, 1'b1, 8'h00, 6'h3F);
        chk("rd_0x3F", Data_out, 8'h00);

        cyc(1'b0, 1'b0, 8'h04, 6'h01);
        chk("wr_no_echo", Data_out, 8'h00);
        cyc(1'b0, 1'b1, 8'h05, 6'h01);
        chk("rd_0x01", Data_out, 8'h04);
        cyc(1'b0, 1'b1, 8'h00, 6'h01);
        chk("rd_0x01_again", Data_out, 8'h04);

        cyc(1'b0, 1'b0, 8'hA5, 6'h09);
        cyc(1'b0, 1'b0, 8'h5A, 6'h08);
        chk("wr_hold", Data_out, 8'h04);
        cyc(1'b0, 1'b1, 8'h00, 6'h09);
        chk("rd_r1c1", Data_out, 8'hA5);
        cyc(1'b0, 1'b1, 8'h00, 6'h08);
        chk("rd_r1c0", Data_out, 8'h5A);
        cyc(1'b0, 1'b1, 8'h00, 6'h01);
        chk("rd_r0c1", Data_out, 8'h04);

        cyc(1'b1, 1'b0, 8'hFF, 6'h01);
        chk("desel_wr_hold", Data_out, 8'h04);
        cyc(1'b1, 1'b1, 8'h00, 6'h09);
        chk("desel_rd_hold", Data_out, 8'h04);
        cyc(1'b0, 1'b1, 8'h00, 6'h01);
        chk("desel_no_wr", Data_out, 8'h04);

        for (int a = 0; a < 64; a++) begin
            logic [7:0] exp_d;
            exp_d = 8'(a) ^ 8'h3C;
            cyc(1'b0, 1'b0, exp_d, 6'(a));
            cyc(1'b0, 1'b1, 8'h00, 6'(a));
            chk($sformatf("b2b_%0d", a), Data_out, exp_d);
        end

        // Data_out currently holds 0x3F^0x3C = 0x03; assert reset between edges.
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dout", Data_out, 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b1, 8'h00, 6'h09);
        chk("rst_cleared_0x09", Data_out, 8'h00);
        cyc(1'b0, 1'b1, 8'h00, 6'h3F);
        chk("rst_cleared_0x3F", Data_out, 8'h00);

`ifdef SRAM2D_PARITY_EN
        begin
            logic [63:0] par_snap;
            cyc(1'b0, 1'b0, 8'h03, 6'h10);
            cyc(1'b0, 1'b0, 8'h07, 6'h07);
            par_snap = dut.par_bits;
            force dut.par_bits = par_snap ^ 64'h80;
            cyc(1'b0, 1'b1, 8'h00, 6'h07);
            chk("par_bad_dout", Data_out, 8'h07);
            chk("par_bad_err", {7'b0, parity_err}, 8'h01);
            release dut.par_bits;
            cyc(1'b1, 1'b1, 8'h00, 6'h10);
            chk("par_hold_idle", {7'b0, parity_err}, 8'h01);
            cyc(1'b0, 1'b0, 8'h11, 6'h20);
            chk("par_hold_wr", {7'b0, parity_err}, 8'h01);
            cyc(1'b0, 1'b1, 8'h00, 6'h10);
            chk("par_clean_dout", Data_out, 8'h03);
            chk("par_clean_err", {7'b0, parity_err}, 8'h00);
        end
`else
        cyc(1'b0, 1'b0, 8'h07, 6'h07);
        cyc(1'b0, 1'b1, 8'h00, 6'h07);
        chk("nopar_dout", Data_out, 8'h07);
        chk("nopar_err", {7'b0, parity_err}, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
